// File: rtl/crc_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_checker
// Purpose  : Serial CRC receiver/checker. Accepts a codeword one bit per
//            accepted cycle, MSB first (M data bits followed by K = WPOLY-1
//            CRC bits). It divides the codeword by the generator polynomial
//            with a shift-register divider and reports the recovered data,
//            the final remainder (syndrome) and an error flag.
// Ports    : i_clk    - system clock, rising edge
//            i_rst    - asynchronous active-high reset
//            i_start  - start (or restart) a codeword, samples i_poly
//            i_poly   - generator polynomial, MSB implicit, [K-1:0] stored
//            i_valid  - i_bit is valid this cycle
//            i_bit    - serial codeword bit, MSB first
//            o_busy   - high while receiving
//            o_done   - one-cycle pulse, codeword complete, results valid
//            o_err    - final remainder is nonzero
//            o_crc    - final remainder (syndrome)
//            o_data   - first M received bits, first bit at o_data[M-1]
// Revision : 1.0 - initial release
// ============================================================================
module crc_checker #(
    parameter int M     = 9,
    parameter int WPOLY = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WPOLY-1:0] i_poly,
    input  logic             i_valid,
    input  logic             i_bit,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [WPOLY-2:0] o_crc,
    output logic [M-1:0]     o_data
);

    localparam int c_k  = WPOLY - 1;
    localparam int c_cw = $clog2(M + c_k + 1);

    localparam logic [c_cw-1:0] c_last    = (c_cw)'(M + c_k - 1);
    localparam logic [c_cw-1:0] c_mcnt    = (c_cw)'(M);
    localparam logic [c_cw-1:0] c_cnt_one = (c_cw)'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_recv = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_k-1:0]  r_poly;
    logic [c_k-1:0]  r_rem;
    logic [c_cw-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [c_k-1:0]  r_crc;
    logic [M-1:0]    r_data;

    logic [c_k-1:0]  w_shift;
    logic [c_k-1:0]  w_rem_next;
    logic [M-1:0]    w_data_next;
    logic            w_accept;
    logic            w_last;

    // The generator MSB is always 1 and is implied by the divider structure.
    logic w_unused_poly_msb;
    assign w_unused_poly_msb = i_poly[WPOLY-1];

    // i_start has priority over bit acceptance, so a restart in RECV drops
    // the bit presented in the same cycle.
    assign w_accept = (r_state == c_st_recv) && i_valid && !i_start;
    assign w_last   = w_accept && (r_cnt == c_last);

    // Divider step: shift in the new bit, reduce by the generator whenever
    // the bit shifted out of the top is set.
    generate
        if (c_k == 1) begin : g_shift_k1
            assign w_shift = i_bit;
        end else begin : g_shift_kn
            assign w_shift = {r_rem[c_k-2:0], i_bit};
        end
    endgenerate

    assign w_rem_next = w_shift ^ (r_rem[c_k-1] ? r_poly : '0);

    generate
        if (M == 1) begin : g_data_m1
            assign w_data_next = i_bit;
        end else begin : g_data_mn
            assign w_data_next = {r_data[M-2:0], i_bit};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start) w_state_next = c_st_recv;
            end
            c_st_recv: begin
                if (i_start)     w_state_next = c_st_recv;
                else if (w_last) w_state_next = c_st_done;
            end
            c_st_done: begin
                w_state_next = i_start ? c_st_recv : c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered status flags, derived from the next state so they line up
    // with the state they describe.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == c_st_recv);
            r_done <= (w_state_next == c_st_done);
        end
    end

    // ------------------------------------------------------------------------
    // Divider, counter and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_poly <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_crc  <= '0;
            r_data <= '0;
        end else if (i_start) begin
            // Results of the previous codeword are deliberately kept.
            r_poly <= i_poly[c_k-1:0];
            r_rem  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + c_cnt_one;
            if (r_cnt < c_mcnt) begin
                r_data <= w_data_next;
            end
            if (r_cnt == c_last) begin
                r_crc <= w_rem_next;
                r_err <= |w_rem_next;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;
    assign o_crc  = r_crc;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_crc_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_checker
// Purpose  : Self-checking bench for crc_checker (M=9, CRC-3). Frame vectors
//            come from a table; expected results are queued when a frame is
//            driven and compared when o_done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_checker;

    localparam int M     = 9;
    localparam int WPOLY = 4;
    localparam int K     = WPOLY - 1;
    localparam int N     = M + K;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WPOLY-1:0] poly;
    logic             valid;
    logic             bit_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [K-1:0]     crc;
    logic [M-1:0]     data;

    crc_checker #(.M(M), .WPOLY(WPOLY)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_poly  (poly),
        .i_valid (valid),
        .i_bit   (bit_in),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .o_crc   (crc),
        .o_data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [M-1:0]     data;
        logic [K-1:0]     crc;
        logic [WPOLY-1:0] poly;
        int               stalls;
        logic [M-1:0]     exp_data;
        logic [K-1:0]     exp_crc;
        logic             exp_err;
    } vec_t;

    typedef struct {
        logic [M-1:0] data;
        logic [K-1:0] crc;
        logic         err;
        int           cyc;
    } exp_t;

    vec_t tbl[6];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: polynomial long division of the whole codeword.
    function automatic logic [K-1:0] model_rem(input logic [N-1:0] cw, input logic [WPOLY-1:0] p);
        logic [N-1:0] v;
        v = cw;
        for (int i = N - 1; i >= K; i--) begin
            if (v[i]) v[i -: WPOLY] = v[i -: WPOLY] ^ p;
        end
        return v[K-1:0];
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got o_done=1, expected no pending frame (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("o_data", {23'd0, data}, {23'd0, e.data});
                check("o_crc", {29'd0, crc}, {29'd0, e.crc});
                check("o_err", {31'd0, err}, {31'd0, e.err});
            end
        end
        prev_done = done;
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {31'd0, err},  32'd0);
        check({tag, "_crc"},  {29'd0, crc},  32'd0);
        check({tag, "_data"}, {23'd0, data}, 32'd0);
    endtask

    // Called at posedge+1. Returns at posedge+1 of the DONE cycle.
    task automatic send_frame(input vec_t v);
        logic [N-1:0] cw;
        logic [N-1:0] sm;
        exp_t         e;
        int           n;
        int           j;
        cw = {v.data, v.crc};
        sm = '0;
        n  = 0;
        while (n < v.stalls) begin
            j = $urandom_range(N - 1, 0);
            if (!sm[j]) begin
                sm[j] = 1'b1;
                n++;
            end
        end
        start  = 1'b1;
        poly   = v.poly;
        valid  = 1'b1;     // must be ignored in the start cycle
        bit_in = 1'b1;
        e.data = v.exp_data;
        e.crc  = v.exp_crc;
        e.err  = v.exp_err;
        e.cyc  = cyc + N + 1 + v.stalls;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = N - 1; i >= 0; i--) begin
            if (sm[i]) begin
                valid  = 1'b0;
                bit_in = ~cw[i];
                @(posedge clk); #1;
            end
            valid  = 1'b1;
            bit_in = cw[i];
            @(posedge clk); #1;
        end
        valid  = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("frames_drained", sb.size(), 32'd0);
        sb.delete();
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] cw;

        tbl[0] = '{9'b100000000, 3'b110, 4'b1011, 0, 9'b100000000, 3'b000, 1'b0};
        tbl[1] = '{9'b100000000, 3'b111, 4'b1011, 0, 9'b100000000, 3'b001, 1'b1};
        tbl[2] = '{9'b000000001, 3'b011, 4'b1011, 3, 9'b000000001, 3'b000, 1'b0};
        cw = {9'b101100111, 3'b000};
        tbl[3] = '{9'b101100111, model_rem(cw, 4'b1011), 4'b1011, 2, 9'b101100111, 3'b000, 1'b0};
        cw = {9'b111000101, 3'b000};
        tbl[4] = '{9'b111000101, 3'b000, 4'b1101, 0, 9'b111000101,
                   model_rem(cw, 4'b1101), |model_rem(cw, 4'b1101)};
        cw = {9'b010101010, 3'b000};
        cw[K-1:0] = model_rem(cw, 4'b1001) ^ 3'b100;
        tbl[5] = '{9'b010101010, cw[K-1:0], 4'b1001, 1, 9'b010101010,
                   model_rem(cw, 4'b1001), 1'b1};

        rst = 1'b0; start = 1'b0; poly = '0; valid = 1'b0; bit_in = 1'b0;

        // Asynchronous reset between clock edges.
        #3 rst = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Idle ignores i_valid.
        valid = 1'b1; bit_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 valid = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_data_hold", {23'd0, data}, 32'd0);

        // Table-driven frames.
        for (int t = 0; t < 6; t++) begin
            send_frame(tbl[t]);
            wait_idle();
        end

        // Abort after 5 bits, then a full valid frame.
        start = 1'b1; poly = 4'b1011;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; bit_in = i[0];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        send_frame(tbl[2]);
        wait_idle();

        // Reset mid-frame after 6 bits.
        start = 1'b1; poly = 4'b1011;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1; bit_in = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("midreset_no_done_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames, second start asserted in DONE.
        send_frame(tbl[0]);
        send_frame(tbl[3]);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
